// File: rtl/matrix_level_ctrl.sv
// matrix_level_ctrl: two 3-bit level registers driven by four debounced
// pushbuttons, producing registered F1/F2 position codes for the LED-matrix
// decoder. A channel at full scale (7) blinks its code between 7 and 0.
module matrix_level_ctrl #(
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned BLINK_CYCLES = 12500000,
    parameter logic [2:0]  INIT_LEVEL   = 3'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up1_n,
    input  logic       btn_dn1_n,
    input  logic       btn_up2_n,
    input  logic       btn_dn2_n,
    output logic [2:0] F1,
    output logic [2:0] F2,
    output logic       full1,
    output logic       full2,
    output logic       empty1,
    output logic       empty2
);

    // Counter widths; a parameter of 1 would give $clog2 == 0, so floor at 1 bit.
    localparam int unsigned DEB_W = (DEB_CYCLES   > 1) ? $clog2(DEB_CYCLES)   : 1;
    localparam int unsigned BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [2:0]       LVL_MAX  = 3'd7;
    localparam logic [2:0]       LVL_MIN  = 3'd0;

    // Button index map: 0 = up1, 1 = dn1, 2 = up2, 3 = dn2.
    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned B_UP1   = 0;
    localparam int unsigned B_DN1   = 1;
    localparam int unsigned B_UP2   = 2;
    localparam int unsigned B_DN2   = 3;

    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync_meta;
    logic [NUM_BTN-1:0] sync_q;

    btn_state_t         stable_q [NUM_BTN];
    logic [DEB_W-1:0]   deb_cnt  [NUM_BTN];
    logic [NUM_BTN-1:0] press_q;

    logic [2:0]         lvl1;
    logic [2:0]         lvl2;
    logic [2:0]         lvl1_next;
    logic [2:0]         lvl2_next;

    logic [BLK_W-1:0]   blink_cnt;
    logic               blink_phase;

    // Saturating level step; simultaneous up and down cancel out.
    function automatic logic [2:0] step_level(
        input logic [2:0] lvl,
        input logic       up,
        input logic       dn
    );
        logic [2:0] result;
        result = lvl;
        if (up && !dn) begin
            if (lvl != LVL_MAX) begin
                result = lvl + 3'd1;
            end
        end else if (dn && !up) begin
            if (lvl != LVL_MIN) begin
                result = lvl - 3'd1;
            end
        end
        return result;
    endfunction

    // Gather raw buttons into one vector (active low, 1 = released).
    always_comb begin
        raw        = '1;
        raw[B_UP1] = btn_up1_n;
        raw[B_DN1] = btn_dn1_n;
        raw[B_UP2] = btn_up2_n;
        raw[B_DN2] = btn_dn2_n;
    end

    // Two-flop synchroniser; idles at the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '1;
            sync_q    <= '1;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // Debouncer per button: a new level must persist for DEB_CYCLES consecutive
    // cycles before the stable state follows it; press edge yields a 1-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                stable_q[i] <= BTN_RELEASED;
                deb_cnt[i]  <= '0;
            end
            press_q <= '0;
        end else begin
            press_q <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                btn_state_t sampled;
                sampled = sync_q[i] ? BTN_RELEASED : BTN_PRESSED;
                if (sampled != stable_q[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable_q[i] <= sampled;
                        deb_cnt[i]  <= '0;
                        press_q[i]  <= (sampled == BTN_PRESSED);
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Next level for each channel from this cycle's press pulses.
    always_comb begin
        lvl1_next = step_level(lvl1, press_q[B_UP1], press_q[B_DN1]);
        lvl2_next = step_level(lvl2, press_q[B_UP2], press_q[B_DN2]);
    end

    // Level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl1 <= INIT_LEVEL;
            lvl2 <= INIT_LEVEL;
        end else begin
            lvl1 <= lvl1_next;
            lvl2 <= lvl2_next;
        end
    end

    // Free-running blink timer; phase toggles every BLINK_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    // Registered output stage; only the position code is blink-gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F1     <= INIT_LEVEL;
            F2     <= INIT_LEVEL;
            full1  <= (INIT_LEVEL == LVL_MAX);
            full2  <= (INIT_LEVEL == LVL_MAX);
            empty1 <= (INIT_LEVEL == LVL_MIN);
            empty2 <= (INIT_LEVEL == LVL_MIN);
        end else begin
            F1     <= (lvl1 == LVL_MAX && blink_phase) ? 3'd0 : lvl1;
            F2     <= (lvl2 == LVL_MAX && blink_phase) ? 3'd0 : lvl2;
            full1  <= (lvl1 == LVL_MAX);
            full2  <= (lvl2 == LVL_MAX);
            empty1 <= (lvl1 == LVL_MIN);
            empty2 <= (lvl2 == LVL_MIN);
        end
    end

endmodule

// File: tb/tb_matrix_level_ctrl.sv
// Bench for matrix_level_ctrl: a cycle model driven from the raw button levels
// is compared against every output on each falling clock edge, with directed
// literal checks pinning latency, saturation, blink and debounce behaviour.
module tb_matrix_level_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned BLINK = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;   // 0 = up1, 1 = dn1, 2 = up2, 3 = dn2; active low
    logic [2:0] F1;
    logic [2:0] F2;
    logic       full1;
    logic       full2;
    logic       empty1;
    logic       empty2;

    int checks;
    int errors;

    matrix_level_ctrl #(
        .DEB_CYCLES  (DEB),
        .BLINK_CYCLES(BLINK),
        .INIT_LEVEL  (3'd0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up1_n(btn[0]),
        .btn_dn1_n(btn[1]),
        .btn_up2_n(btn[2]),
        .btn_dn2_n(btn[3]),
        .F1       (F1),
        .F2       (F2),
        .full1    (full1),
        .full2    (full2),
        .empty1   (empty1),
        .empty2   (empty2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_s1     [4];
    logic        m_s2     [4];
    logic        m_stable [4];   // raw level the debouncer currently believes
    int unsigned m_run    [4];   // consecutive cycles seen differing
    logic        m_pulse  [4];
    int unsigned m_lvl    [2];
    int unsigned m_f      [2];
    logic        m_full   [2];
    logic        m_empty  [2];
    int unsigned m_edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_stable[b] = 1'b1;
                m_run[b] = 0;   m_pulse[b] = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                m_lvl[c] = 0; m_f[c] = 0; m_full[c] = 1'b0; m_empty[c] = 1'b1;
            end
            m_edges = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic up, dn;
                m_f[c]     = (m_lvl[c] == 7 && ((m_edges / BLINK) % 2 == 1)) ? 0 : m_lvl[c];
                m_full[c]  = (m_lvl[c] == 7);
                m_empty[c] = (m_lvl[c] == 0);
                up = m_pulse[2*c];
                dn = m_pulse[2*c+1];
                if (up && !dn && m_lvl[c] < 7) m_lvl[c] = m_lvl[c] + 1;
                else if (dn && !up && m_lvl[c] > 0) m_lvl[c] = m_lvl[c] - 1;
            end
            for (int b = 0; b < 4; b++) begin
                m_pulse[b] = 1'b0;
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == DEB) begin
                        m_stable[b] = m_s2[b];
                        m_run[b]    = 0;
                        m_pulse[b]  = (m_s2[b] == 1'b0);
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = btn[b];
            end
            m_edges = m_edges + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] exp;
        act = {F1, F2, full1, full2, empty1, empty2};
        exp = {m_f[0][2:0], m_f[1][2:0], m_full[0], m_full[1], m_empty[0], m_empty[1]};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got F1F2/fl/em=%b want %b", $time, act, exp);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] mask, input int unsigned low_cycles,
                         input int unsigned idle_cycles);
        @(negedge clk);
        btn = btn & ~mask;
        repeat (low_cycles) @(negedge clk);
        btn = btn | mask;
        repeat (idle_cycles) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        int unsigned sevens;
        int unsigned zeros;
        int unsigned sixes;
        int unsigned f1_before;
        checks = 0;
        errors = 0;
        btn    = 4'b1111;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_F1", int'(F1), 0);
        check("reset_empty1", int'(empty1), 1);

        // Bring ch1 to 5, then assert reset mid-cycle.
        repeat (5) press(4'b0001, 6, 10);
        check("setup_F1_5", int'(F1), 5);
        #2 rst_n = 1'b0;
        #1;
        check("async_F1", int'(F1), 0);
        check("async_F2", int'(F2), 0);
        check("async_empty", int'({empty1, empty2}), 3);
        check("async_full", int'({full1, full2}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Press-to-output latency.
        btn[0] = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (F1 == 3'd1) break;
        end
        check("latency_up1", int'(n), 8);
        repeat (20 - n) @(negedge clk);
        btn[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("held_once_F1", int'(F1), 1);
        check("held_F2", int'(F2), 0);

        // Floor on ch1.
        press(4'b0010, 6, 10);
        check("dn_to_0", int'(F1), 0);
        press(4'b0010, 6, 10);
        check("floor_F1", int'(F1), 0);
        check("floor_empty1", int'(empty1), 1);

        // Saturation and blink on ch2.
        repeat (9) press(4'b0100, 6, 10);
        check("sat_full2", int'(full2), 1);
        sevens = 0;
        zeros  = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (F2 == 3'd7) sevens++;
            if (F2 == 3'd0) zeros++;
        end
        check("blink_sevens", int'(sevens), 8);
        check("blink_zeros", int'(zeros), 8);
        press(4'b1000, 6, 10);
        check("unsat_full2", int'(full2), 0);
        sixes = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (F2 == 3'd6) sixes++;
        end
        check("steady_six", int'(sixes), 16);

        // Bounce and short glitch on dn2.
        repeat (5) press(4'b1000, 2, 2);
        repeat (8) @(negedge clk);
        check("bounce_F2", int'(F2), 6);
        press(4'b1000, 3, 12);
        check("glitch_F2", int'(F2), 6);

        // Simultaneous events.
        press(4'b0001, 6, 10);
        f1_before = F1;
        check("pre_sim_F1", int'(f1_before), 1);
        press(4'b0011, 6, 10);
        check("up_dn_cancel", int'(F1), 1);
        press(4'b0101, 6, 10);
        check("both_up_F1", int'(F1), 2);
        check("both_up_full2", int'(full2), 1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
